// File: rtl/cart_mbc1_responder.sv
// Cartridge-side MBC1-style responder for the external memory bus.
// Synchronizes the host bus, commits control-register and RAM writes on the
// /WR rising edge, and serves ROM/RAM reads by driving D back to the host.
module cart_mbc1_responder #(
    parameter int ROM_BANK_BITS = 7,
    parameter int RAM_BANK_BITS = 2,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                       clk2,
    input  logic                       n_reset2,
    input  logic [15:0]                ext_a,
    input  logic [7:0]                 ext_d_in,
    output logic [7:0]                 ext_d_out,
    output logic                       ext_d_oe,
    input  logic                       ext_n_wr,
    input  logic                       ext_n_rd,
    input  logic                       ext_n_cs,
    output logic [ROM_BANK_BITS+13:0]  rom_addr,
    output logic                       rom_re,
    input  logic [7:0]                 rom_rdata,
    output logic [RAM_BANK_BITS+12:0]  ram_addr,
    output logic                       ram_re,
    output logic                       ram_we,
    output logic [7:0]                 ram_wdata,
    input  logic [7:0]                 ram_rdata,
    output logic                       ram_enabled
);

    // All bus inputs travel through one packed synchronizer word so every
    // field sees identical delay: {a[15:0], d[7:0], n_wr, n_rd, n_cs}.
    localparam int SW = 27;
    localparam logic [SW-1:0] SYNC_IDLE = {16'h0000, 8'h00, 3'b111};
    localparam int CW = $clog2(SYNC_STAGES + 1);
    localparam logic [CW-1:0] SETTLE_MAX = CW'(SYNC_STAGES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRIVE,
        ST_IGNORE
    } rd_state_t;

    logic [SW-1:0] sync_in;
    logic [SW-1:0] sync_out;

    assign sync_in = {ext_a, ext_d_in, ext_n_wr, ext_n_rd, ext_n_cs};

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic [SW-1:0] stage_in;
            logic [SW-1:0] stage_reg;
            if (gi == 0) begin : g_first
                assign stage_in = sync_in;
            end else begin : g_next
                assign stage_in = g_sync[gi-1].stage_reg;
            end
            // One synchronizer stage; resets to the idle bus pattern.
            always_ff @(posedge clk2 or negedge n_reset2) begin
                if (!n_reset2) stage_reg <= SYNC_IDLE;
                else           stage_reg <= stage_in;
            end
        end
    endgenerate

    assign sync_out = g_sync[SYNC_STAGES-1].stage_reg;

    logic [15:0] s_a;
    logic [7:0]  s_d;
    logic        s_wr;
    logic        s_rd;
    logic        s_cs;

    assign s_a  = sync_out[26:11];
    assign s_d  = sync_out[10:3];
    assign s_wr = sync_out[2];
    assign s_rd = sync_out[1];
    assign s_cs = sync_out[0];

    // Write-path state
    logic [15:0]   hold_a_reg;
    logic [7:0]    hold_d_reg;
    logic          hold_cs_reg;
    logic          wr_prev_reg;
    logic          wr_armed_reg;
    logic [CW-1:0] settle_cnt_reg;
    logic          settled;
    logic          commit;

    // Banking registers
    logic          ram_en_reg;
    logic [4:0]    rom_bank5_reg;
    logic [1:0]    upper2_reg;
    logic          mode_reg;

    // The synchronizer holds reset-injected idle values for SYNC_STAGES
    // cycles after release; a /WR high seen before then is not real.
    assign settled = (settle_cnt_reg == SETTLE_MAX);

    // A commit needs a genuine high->low->high /WR sequence observed after
    // reset, so a write interrupted by reset can never complete.
    assign commit = wr_armed_reg & ~wr_prev_reg & s_wr;

    // Capture the write cycle while /WR is low and track the /WR edge.
    always_ff @(posedge clk2 or negedge n_reset2) begin
        if (!n_reset2) begin
            hold_a_reg     <= '0;
            hold_d_reg     <= '0;
            hold_cs_reg    <= 1'b1;
            wr_prev_reg    <= 1'b1;
            wr_armed_reg   <= 1'b0;
            settle_cnt_reg <= '0;
        end else begin
            wr_prev_reg <= s_wr;
            if (!settled) settle_cnt_reg <= settle_cnt_reg + CW'(1);
            if (settled && s_wr) wr_armed_reg <= 1'b1;
            if (!s_wr) begin
                hold_a_reg  <= s_a;
                hold_d_reg  <= s_d;
                hold_cs_reg <= s_cs;
            end
        end
    end

    // Commit control-register writes on the /WR rising edge.
    always_ff @(posedge clk2 or negedge n_reset2) begin
        if (!n_reset2) begin
            ram_en_reg    <= 1'b0;
            rom_bank5_reg <= 5'h01;
            upper2_reg    <= 2'b00;
            mode_reg      <= 1'b0;
        end else if (commit) begin
            case (hold_a_reg[15:13])
                3'b000: ram_en_reg <= (hold_d_reg[3:0] == 4'hA);
                3'b001: rom_bank5_reg <= (hold_d_reg[4:0] == 5'h00) ? 5'h01 : hold_d_reg[4:0];
                3'b010: upper2_reg <= hold_d_reg[1:0];
                3'b011: mode_reg <= hold_d_reg[0];
                default: ;
            endcase
        end
    end

    // Address mapping
    logic [6:0] rom_bank_lo;
    logic [6:0] rom_bank_hi;
    logic [6:0] rom_bank_full;
    logic [1:0] ram_bank_full;
    logic       ram_we_c;

    assign rom_bank_lo   = mode_reg ? {upper2_reg, 5'b00000} : 7'd0;
    assign rom_bank_hi   = {upper2_reg, rom_bank5_reg};
    assign rom_bank_full = s_a[14] ? rom_bank_hi : rom_bank_lo;
    assign rom_addr      = {ROM_BANK_BITS'(rom_bank_full), s_a[13:0]};

    assign ram_bank_full = mode_reg ? upper2_reg : 2'b00;
    assign ram_we_c      = commit & (hold_a_reg[15:13] == 3'b101) & ~hold_cs_reg & ram_en_reg;
    assign ram_addr      = {RAM_BANK_BITS'(ram_bank_full),
                            ram_we_c ? hold_a_reg[12:0] : s_a[12:0]};
    assign ram_we        = ram_we_c;
    assign ram_wdata     = hold_d_reg;
    assign ram_enabled   = ram_en_reg;

    // Read FSM
    rd_state_t   state_reg, state_next;
    logic [7:0]  dout_reg, dout_next;
    logic        oe_reg, oe_next;
    logic        fetch_ram_reg, fetch_ram_next;
    logic [15:0] drive_a_reg, drive_a_next;
    logic        rom_re_c;
    logic        ram_re_c;

    // Read FSM state and data-driver registers.
    always_ff @(posedge clk2 or negedge n_reset2) begin
        if (!n_reset2) begin
            state_reg     <= ST_IDLE;
            dout_reg      <= '0;
            oe_reg        <= 1'b0;
            fetch_ram_reg <= 1'b0;
            drive_a_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            dout_reg      <= dout_next;
            oe_reg        <= oe_next;
            fetch_ram_reg <= fetch_ram_next;
            drive_a_reg   <= drive_a_next;
        end
    end

    // Read FSM next-state logic; a concurrent /WR low always wins over /RD.
    always_comb begin
        state_next     = state_reg;
        dout_next      = dout_reg;
        oe_next        = oe_reg;
        fetch_ram_next = fetch_ram_reg;
        drive_a_next   = drive_a_reg;
        rom_re_c       = 1'b0;
        ram_re_c       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                oe_next = 1'b0;
                if (!s_rd && s_wr) begin
                    drive_a_next = s_a;
                    if (!s_a[15]) begin
                        rom_re_c       = 1'b1;
                        fetch_ram_next = 1'b0;
                        state_next     = ST_FETCH;
                    end else if (s_a[15:13] == 3'b101 && !s_cs && ram_en_reg) begin
                        ram_re_c       = 1'b1;
                        fetch_ram_next = 1'b1;
                        state_next     = ST_FETCH;
                    end else begin
                        state_next = ST_IGNORE;
                    end
                end
            end
            ST_FETCH: begin
                if (!s_wr) begin
                    oe_next    = 1'b0;
                    state_next = ST_IDLE;
                end else begin
                    dout_next  = fetch_ram_reg ? ram_rdata : rom_rdata;
                    oe_next    = 1'b1;
                    state_next = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (s_rd || !s_wr || (s_a != drive_a_reg)) begin
                    oe_next    = 1'b0;
                    state_next = ST_IDLE;
                end
            end
            ST_IGNORE: begin
                oe_next = 1'b0;
                if (s_rd) state_next = ST_IDLE;
            end
            default: begin
                oe_next    = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

    assign rom_re    = rom_re_c;
    assign ram_re    = ram_re_c;
    assign ext_d_out = dout_reg;
    assign ext_d_oe  = oe_reg;

endmodule

// File: doc/cart_mbc1_responder.md
Name: cart_mbc1_responder

Overview:
- Cartridge-side responder for the external memory bus that the SoC drives: A[15:0], D[7:0], /WR, /RD, /CS.
- Resolves host bus cycles into MBC1-style control-register writes, ROM reads and banked external-RAM reads/writes.
- Presents synchronous ROM/RAM memory ports and drives D back onto the bus during read cycles.
- Used as the bench/FPGA counterpart of the SoC external bus.

Parameters:
ROM_BANK_BITS, 7, width of the effective ROM bank number (2^ROM_BANK_BITS banks of 16 KiB).
RAM_BANK_BITS, 2, width of the effective RAM bank number (8 KiB banks).
SYNC_STAGES, 2, flip-flop synchronizer depth on all bus inputs (minimum 2).

Ports:
clk2  in  1  responder clock; must be ≥4x the bus strobe rate.
n_reset2  in  1  asynchronous active-low reset.
ext_a  in  16  bus address as seen at the cartridge pins.
ext_d_in  in  8  bus data from host.
ext_d_out  out  8  data driven to host.
ext_d_oe  out  1  1 = cartridge drives D.
ext_n_wr  in  1  bus write strobe, active low.
ext_n_rd  in  1  bus read strobe, active low.
ext_n_cs  in  1  RAM chip select (A000-BFFF), active low.
rom_addr  out  ROM_BANK_BITS+14  ROM byte address.
rom_re  out  1  ROM read request.
rom_rdata  in  8  ROM data, valid one clk2 after rom_re.
ram_addr  out  RAM_BANK_BITS+13  RAM byte address.
ram_re  out  1  RAM read request.
ram_we  out  1  RAM write strobe, one cycle.
ram_wdata  out  8  RAM write data.
ram_rdata  in  8  RAM data, valid one clk2 after ram_re.
ram_enabled  out  1  current RAM-enable register, for debug.

Behaviour:
- Reset (async assert, sync deassert):
  - ram_en=0, rom_bank5=5'h01, upper2=0, mode=0, synchronizers=1/idle.
  - All outputs 0; rom_re, ram_re, ram_we and ext_d_oe are 0.
- Input sync: ext_a, ext_d_in, ext_n_wr, ext_n_rd and ext_n_cs each pass through SYNC_STAGES flops. All decode uses synced values (s_a, s_d, s_wr, s_rd, s_cs).
- Write cycle:
  - While s_wr=0, capture s_a, s_d and s_cs every cycle into hold registers.
  - On the s_wr 0->1 edge, commit exactly once using the hold registers (the last values seen with /WR low).
  - Commit decode:
    - 0000-1FFF: ram_en = (d[3:0]==4'hA).
    - 2000-3FFF: rom_bank5 = d[4:0]; a written value of 0 stores 1 (00->01, 20->01; 21 stays 01 only after masking, see below).
    - 4000-5FFF: upper2 = d[1:0].
    - 6000-7FFF: mode = d[0].
    - A000-BFFF with hold_cs=0 and ram_en=1: ram_we=1 for one cycle; ram_addr and ram_wdata per the mapping below.
    - A000-BFFF with ram_en=0: write ignored.
    - All other addresses: ignored.
- Address mapping:
  - ROM 0000-3FFF: bank = mode ? {upper2,5'b0} : 0.
  - ROM 4000-7FFF: bank = {upper2, rom_bank5}.
  - The bank is truncated to ROM_BANK_BITS. Zero-to-one translation applies to rom_bank5 only, before truncation.
  - rom_addr = {bank, a[13:0]}.
  - RAM: bank = mode ? upper2 : 0, truncated to RAM_BANK_BITS; ram_addr = {bank, a[12:0]}.
- Read FSM states:
  - IDLE:
    - s_rd=0 and s_wr=1, a<8000 -> pulse rom_re, go FETCH.
    - s_rd=0, s_wr=1, A000-BFFF, s_cs=0, ram_en=1 -> pulse ram_re, go FETCH.
    - Any other read -> go IGNORE (ext_d_oe stays 0; the bus floats).
  - FETCH (1 cycle): latch rom_rdata or ram_rdata into ext_d_out, set ext_d_oe=1, go DRIVE.
  - DRIVE: hold ext_d_out and ext_d_oe until s_rd=1 -> ext_d_oe=0, go IDLE. If s_a changes while in DRIVE, go IDLE and re-fetch next cycle.
  - IGNORE: wait for s_rd=1 -> IDLE.
- Latency:
  - ext_d_oe rises SYNC_STAGES+2 clk2 after the /RD fall at the pins.
  - ext_d_oe drops SYNC_STAGES+1 clk2 after the /RD rise.
- Simultaneous events:
  - s_rd=0 with s_wr=0 is treated as a write; the read FSM stays in IDLE or IGNORE and ext_d_oe is forced 0.
  - A register commit in the same cycle as a FETCH does not alter the in-flight fetch. The new banking applies from the next fetch.
- Reset mid-cycle: all outputs go to 0 immediately. A write in progress is lost; no ram_we is generated after reset release until a fresh /WR low->high edge.

Test Plan:
- Reset, then read 4123 -> rom_re=1, rom_addr=0x04123 (bank 1); ext_d_out=rom_rdata, ext_d_oe=1 until /RD rises.
- Write 2000<=00 -> rom_bank5=1. Write 2000<=05, read 4000 -> rom_addr=0x14000. Write 4000<=02, read 4000 -> rom_addr=0x114000.
- Mode: write 6000<=01 and 4000<=01, read 0010 -> rom_addr=0x080010. Write 6000<=00, read 0010 -> rom_addr=0x000010.
- RAM disabled: write A005<=5A with /CS low -> no ram_we; read A005 -> ext_d_oe stays 0. Write 0000<=0A, then A005<=5A -> exactly one ram_we, ram_addr=0x0005, ram_wdata=0x5A.
- Banked RAM: mode=1, 4000<=03, write BFFF<=C3 -> ram_addr=0x7FFF. Read back -> ext_d_out=0xC3.
- Assert n_reset2 during /WR low, release, then raise /WR -> no ram_we and no register change; all registers at reset values.
